// File: rtl/decode_stage_if.sv
// Fetch-side, writeback-side and execute-side signals of decode_stage.
// master = the environment driving fetch/wb/execute; slave = decode_stage.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic            flush;
    logic [4:0]      wb_rd;
    logic            wb_write;
    logic [XLEN-1:0] wb_value;
    logic [4:0]      rs1_unreg_out;
    logic [4:0]      rs2_unreg_out;
    logic            rs1_read_unreg_out;
    logic            rs2_read_unreg_out;
    logic            out_ready;
    logic            valid_out;
    logic [XLEN-1:0] pc_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic            rd_write_out;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;
    logic [6:0]      alu_op_out;
    logic            alu_sub_sra_out;
    logic [2:0]      alu_src1_out;
    logic [2:0]      alu_src2_out;
    logic [XLEN-1:0] rs1_value_out;
    logic [XLEN-1:0] rs2_value_out;
    logic [XLEN-1:0] imm_value_out;
    logic            illegal_out;

    modport master (
        output in_valid, instr_in, pc_in, flush, wb_rd, wb_write, wb_value, out_ready,
        input  in_ready, rs1_unreg_out, rs2_unreg_out, rs1_read_unreg_out, rs2_read_unreg_out,
               valid_out, pc_out, rs1_out, rs2_out, rd_out, rd_write_out, funct3_out,
               funct7_out, alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out,
               rs1_value_out, rs2_value_out, imm_value_out, illegal_out
    );

    modport slave (
        input  in_valid, instr_in, pc_in, flush, wb_rd, wb_write, wb_value, out_ready,
        output in_ready, rs1_unreg_out, rs2_unreg_out, rs1_read_unreg_out, rs2_read_unreg_out,
               valid_out, pc_out, rs1_out, rs2_out, rd_out, rd_write_out, funct3_out,
               funct7_out, alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out,
               rs1_value_out, rs2_value_out, imm_value_out, illegal_out
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with internal register file; DEC_WB_BYPASS_EN forwards same-cycle writeback to reads.
// Latency: one cycle from accepted input to output register.
// Backpressure: in_ready = flush || ((out_ready || !valid_out) && !load_use_hazard); outputs hold while stalled.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic           req,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic idx_bad(input logic [4:0] idx);
        return int'(idx) >= NREG;
    endfunction

    logic [XLEN-1:0] regs [NREG];

    logic [31:0] ins;
    logic [6:0]  opc;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic        is_r, is_iop, is_load, is_jalr, is_store, is_branch, is_lui, is_auipc, is_jal;
    logic        known, rd_used, rs1_rd, rs2_rd, illegal, sub_sra, hazard;
    logic [4:0]  rs1_idx, rs2_idx;
    logic signed [31:0] imm32;
    logic [2:0]  src1, src2;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign ins   = bus.instr_in;
    assign opc   = ins[6:0];
    assign rd_f  = ins[11:7];
    assign rs1_f = ins[19:15];
    assign rs2_f = ins[24:20];

    assign is_r      = (opc == OP_R);
    assign is_iop    = (opc == OP_IMM);
    assign is_load   = (opc == OP_LOAD);
    assign is_jalr   = (opc == OP_JALR);
    assign is_store  = (opc == OP_STORE);
    assign is_branch = (opc == OP_BRANCH);
    assign is_lui    = (opc == OP_LUI);
    assign is_auipc  = (opc == OP_AUIPC);
    assign is_jal    = (opc == OP_JAL);

    assign known   = is_r | is_iop | is_load | is_jalr | is_store | is_branch | is_lui | is_auipc | is_jal;
    assign rd_used = is_r | is_iop | is_load | is_jalr | is_lui | is_auipc | is_jal;
    assign rs1_rd  = is_r | is_iop | is_load | is_store | is_branch | is_jalr;
    assign rs2_rd  = is_r | is_store | is_branch;
    assign illegal = !known || (rs1_rd && idx_bad(rs1_f)) || (rs2_rd && idx_bad(rs2_f))
                     || (rd_used && idx_bad(rd_f));
    assign rs1_idx = rs1_rd ? rs1_f : 5'd0;
    assign rs2_idx = rs2_rd ? rs2_f : 5'd0;
    assign sub_sra = (is_r || (is_iop && ins[14:12] == 3'b101)) ? ins[30] : 1'b0;

    assign bus.rs1_unreg_out      = rs1_idx;
    assign bus.rs2_unreg_out      = rs2_idx;
    assign bus.rs1_read_unreg_out = rs1_rd;
    assign bus.rs2_read_unreg_out = rs2_rd;

    // Jumps compute the link value pc+4 in the ALU; the target adder lives elsewhere.
    always_comb begin
        imm32 = '0;
        src1  = 3'd0;
        src2  = 3'd0;
        case (opc)
            OP_IMM, OP_LOAD: begin
                imm32 = {{20{ins[31]}}, ins[31:20]};
                src2  = 3'd1;
            end
            OP_JALR: begin
                imm32 = {{20{ins[31]}}, ins[31:20]};
                src1  = 3'd1;
                src2  = 3'd2;
            end
            OP_STORE: begin
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                src2  = 3'd1;
            end
            OP_BRANCH: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI: begin
                imm32 = {ins[31:12], 12'b0};
                src1  = 3'd2;
                src2  = 3'd1;
            end
            OP_AUIPC: begin
                imm32 = {ins[31:12], 12'b0};
                src1  = 3'd1;
                src2  = 3'd1;
            end
            OP_JAL: begin
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                src1  = 3'd1;
                src2  = 3'd2;
            end
            default: ;
        endcase
    end

    always_comb begin
        rs1_val = '0;
        if (rs1_idx != 5'd0 && !idx_bad(rs1_idx)) begin
            rs1_val = regs[rs1_idx[AW-1:0]];
`ifdef DEC_WB_BYPASS_EN
            if (bus.wb_write && bus.wb_rd == rs1_idx) rs1_val = bus.wb_value;
`endif
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2_idx != 5'd0 && !idx_bad(rs2_idx)) begin
            rs2_val = regs[rs2_idx[AW-1:0]];
`ifdef DEC_WB_BYPASS_EN
            if (bus.wb_write && bus.wb_rd == rs2_idx) rs2_val = bus.wb_value;
`endif
        end
    end

    assign hazard = bus.valid_out && (bus.alu_op_out == OP_LOAD) && (bus.rd_out != 5'd0)
                    && ((rs1_rd && rs1_f == bus.rd_out) || (rs2_rd && rs2_f == bus.rd_out));
    assign bus.in_ready = bus.flush || ((bus.out_ready || !bus.valid_out) && !hazard);

    always_ff @(posedge req) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.wb_write && bus.wb_rd != 5'd0 && !idx_bad(bus.wb_rd)) begin
            regs[bus.wb_rd[AW-1:0]] <= bus.wb_value;
        end
    end

    always_ff @(posedge req) begin
        if (rst) begin
            bus.valid_out       <= 1'b0;
            bus.pc_out          <= '0;
            bus.rs1_out         <= '0;
            bus.rs2_out         <= '0;
            bus.rd_out          <= '0;
            bus.rd_write_out    <= 1'b0;
            bus.funct3_out      <= '0;
            bus.funct7_out      <= '0;
            bus.alu_op_out      <= '0;
            bus.alu_sub_sra_out <= 1'b0;
            bus.alu_src1_out    <= '0;
            bus.alu_src2_out    <= '0;
            bus.rs1_value_out   <= '0;
            bus.rs2_value_out   <= '0;
            bus.imm_value_out   <= '0;
            bus.illegal_out     <= 1'b0;
        end else if (bus.flush) begin
            bus.valid_out <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            bus.valid_out       <= 1'b1;
            bus.pc_out          <= bus.pc_in;
            bus.rs1_out         <= rs1_idx;
            bus.rs2_out         <= rs2_idx;
            bus.rd_out          <= rd_used ? rd_f : 5'd0;
            bus.rd_write_out    <= rd_used && (rd_f != 5'd0) && !illegal;
            bus.funct3_out      <= ins[14:12];
            bus.funct7_out      <= ins[31:25];
            bus.alu_op_out      <= opc;
            bus.alu_sub_sra_out <= sub_sra;
            bus.alu_src1_out    <= src1;
            bus.alu_src2_out    <= src2;
            bus.rs1_value_out   <= rs1_val;
            bus.rs2_value_out   <= rs2_val;
            bus.imm_value_out   <= XLEN'(imm32);
            bus.illegal_out     <= illegal;
        end else if (bus.out_ready) begin
            bus.valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; expected values are hand-derived from the RV32I encodings.
module tb_decode_stage;
    logic req = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    decode_stage_if #(.XLEN(32)) bus ();
    decode_stage #(.XLEN(32), .NREG(32)) dut (.req(req), .rst(rst), .bus(bus));

    always #5 req = ~req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge req);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.instr_in = instr;
        bus.pc_in    = pc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] val);
        bus.wb_write = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_value = val;
        tick();
        bus.wb_write = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_byp;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr_in  = '0;
        bus.pc_in     = '0;
        bus.flush     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_write  = 1'b0;
        bus.wb_value  = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_valid", 32'(bus.valid_out), 0);
        check("rst_pc", bus.pc_out, 0);
        check("rst_imm", bus.imm_value_out, 0);
        check("rst_illegal", 32'(bus.illegal_out), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.instr_in = enc_r(7'h00, 5'(i), 5'(i), 3'b000, 5'd1, 7'h33);
            #1;
            check("read_rs1_idx", 32'(bus.rs1_unreg_out), 32'(i));
            tick();
            check("read_valid", 32'(bus.valid_out), 1);
            check("read_rs1_val", bus.rs1_value_out, 0);
            check("read_rs2_val", bus.rs2_value_out, 0);
        end
        bus.in_valid = 1'b0;

        wb(5'd5, 32'h1234);
        wb(5'd0, 32'hDEAD);

        issue(enc_i(12'hFFF, 5'd5, 3'b000, 5'd6, 7'h13), 32'h40);
        check("addi_rs1_val", bus.rs1_value_out, 32'h1234);
        check("addi_imm", bus.imm_value_out, 32'hFFFF_FFFF);
        check("addi_src2", 32'(bus.alu_src2_out), 1);
        check("addi_src1", 32'(bus.alu_src1_out), 0);
        check("addi_rd", 32'(bus.rd_out), 6);
        check("addi_rd_write", 32'(bus.rd_write_out), 1);
        check("addi_op", 32'(bus.alu_op_out), 32'h13);
        check("addi_rs2_unread", 32'(bus.rs2_out), 0);
        check("addi_pc", bus.pc_out, 32'h40);

        issue(enc_r(7'h00, 5'd5, 5'd0, 3'b000, 5'd11, 7'h33), 32'h44);
        check("x0_reads_zero", bus.rs1_value_out, 0);
        check("add_rs2_val", bus.rs2_value_out, 32'h1234);

        // Load-use: one stall cycle, one bubble
        bus.in_valid = 1'b1;
        bus.instr_in = enc_i(12'h000, 5'd5, 3'b010, 5'd7, 7'h03);
        tick();
        check("lw_op", 32'(bus.alu_op_out), 32'h03);
        check("lw_rd", 32'(bus.rd_out), 7);
        bus.instr_in = enc_r(7'h00, 5'd7, 5'd7, 3'b000, 5'd8, 7'h33);
        #1;
        check("lu_stall", 32'(bus.in_ready), 0);
        tick();
        check("lu_bubble", 32'(bus.valid_out), 0);
        check("lu_release", 32'(bus.in_ready), 1);
        tick();
        check("lu_add_valid", 32'(bus.valid_out), 1);
        check("lu_add_rd", 32'(bus.rd_out), 8);
        check("lu_add_rs1", 32'(bus.rs1_out), 7);
        bus.instr_in = enc_i(12'h000, 5'd5, 3'b010, 5'd7, 7'h03);
        tick();
        bus.instr_in = 32'h12345_3B7;
        #1;
        check("lw_lui_no_stall", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;

        // Same-cycle writeback to a register being read
        bus.in_valid = 1'b1;
        bus.instr_in = enc_r(7'h00, 5'd0, 5'd9, 3'b000, 5'd1, 7'h33);
        bus.wb_write = 1'b1;
        bus.wb_rd    = 5'd9;
        bus.wb_value = 32'hAA;
        tick();
        bus.wb_write = 1'b0;
        bus.in_valid = 1'b0;
`ifdef DEC_WB_BYPASS_EN
        exp_byp = 32'hAA;
`else
        exp_byp = 32'h0;
`endif
        check("wb_same_cycle", bus.rs1_value_out, exp_byp);
        issue(enc_r(7'h00, 5'd0, 5'd9, 3'b000, 5'd1, 7'h33), 32'h50);
        check("wb_after", bus.rs1_value_out, 32'hAA);
        tick();

        // Stall with BEQ held in the output register
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = enc_b(13'h1FF8, 5'd9, 5'd5, 3'b000);
        bus.pc_in     = 32'h100;
        tick();
        bus.instr_in  = enc_i(12'h005, 5'd0, 3'b000, 5'd3, 7'h13);
        bus.pc_in     = 32'h104;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_valid", 32'(bus.valid_out), 1);
            check("hold_imm", bus.imm_value_out, 32'hFFFF_FFF8);
            check("hold_pc", bus.pc_out, 32'h100);
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_rs2_val", bus.rs2_value_out, 32'hAA);
            tick();
        end
        check("beq_rd_write", 32'(bus.rd_write_out), 0);
        check("beq_op", 32'(bus.alu_op_out), 32'h63);
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("after_hold_imm", bus.imm_value_out, 5);
        check("after_hold_pc", bus.pc_out, 32'h104);
        check("after_hold_rd", 32'(bus.rd_out), 3);

        // Flush overrides a stalled output and a presented input
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd1, 7'h33);
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", 32'(bus.valid_out), 0);
        bus.out_ready = 1'b1;

        bus.in_valid = 1'b1;
        bus.instr_in = 32'h0000_007F;
        #1;
        check("illegal_no_rs1", 32'(bus.rs1_read_unreg_out), 0);
        tick();
        bus.in_valid = 1'b0;
        check("illegal_flag", 32'(bus.illegal_out), 1);
        check("illegal_rd_write", 32'(bus.rd_write_out), 0);
        check("illegal_valid", 32'(bus.valid_out), 1);

        issue(32'h0010_00EF, 32'h200);
        check("jal_imm", bus.imm_value_out, 32'h800);
        check("jal_src1", 32'(bus.alu_src1_out), 1);
        check("jal_src2", 32'(bus.alu_src2_out), 2);
        check("jal_rd_write", 32'(bus.rd_write_out), 1);
        check("jal_legal", 32'(bus.illegal_out), 0);

        issue(32'h1234_5137, 32'h204);
        check("lui_imm", bus.imm_value_out, 32'h1234_5000);
        check("lui_src1", 32'(bus.alu_src1_out), 2);

        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33), 32'h208);
        check("sub_sel", 32'(bus.alu_sub_sra_out), 1);
        issue(enc_i(12'h403, 5'd1, 3'b101, 5'd4, 7'h13), 32'h20C);
        check("srai_sel", 32'(bus.alu_sub_sra_out), 1);
        check("srai_imm", bus.imm_value_out, 32'h403);
        issue(enc_i(12'h400, 5'd1, 3'b000, 5'd4, 7'h13), 32'h210);
        check("addi_b30_sel", 32'(bus.alu_sub_sra_out), 0);

        issue(enc_s(12'hFFC, 5'd5, 5'd1, 3'b010), 32'h214);
        check("sw_imm", bus.imm_value_out, 32'hFFFF_FFFC);
        check("sw_rs2_val", bus.rs2_value_out, 32'h1234);
        check("sw_rd_write", 32'(bus.rd_write_out), 0);

        // Reset mid-run wins over a concurrent writeback
        rst          = 1'b1;
        bus.wb_write = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_value = 32'h5555;
        tick();
        rst          = 1'b0;
        bus.wb_write = 1'b0;
        check("midrst_valid", 32'(bus.valid_out), 0);
        issue(enc_r(7'h00, 5'd9, 5'd5, 3'b000, 5'd1, 7'h33), 32'h300);
        check("midrst_x5", bus.rs1_value_out, 0);
        check("midrst_x9", bus.rs2_value_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
